spi_xfer_ctrl: RTL and testbench

Byte-level SPI mode-0 master controller that owns and sequences one `clock_divider` instance. It latches the SCLK divisor, configures the divider, asserts chip select, starts the divider for each 8-bit burst, shifts MOSI and samples MISO on the divider's SCLK edges, and hands received bytes back over a valid/ready-style interface. It sits between the host register interface and the SPI pins.

---
 rtl/spi_pkg.sv | 29 ++
 rtl/clock_divider.sv | 56 +++++
 rtl/spi_xfer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer controller.
//   state_t      : controller FSM states
//   DIV_MIN      : smallest legal SCLK divisor
//   cfg_t        : divider configuration word {div[7:0], load}
//   sanitize_div : coerces a requested divisor to a legal even value
package spi_pkg;

  typedef enum logic [2:0] {
    ST_CONFIG,
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_HOLD
  } state_t;

  localparam logic [7:0] DIV_MIN = 8'd2;

  typedef struct packed {
    logic [7:0] div;
    logic       load;
  } cfg_t;

  // 0/1 become the minimum; odd values round down to even.
  function automatic logic [7:0] sanitize_div(input logic [7:0] d);
    if (d < DIV_MIN) return DIV_MIN;
    return {d[7:1], 1'b0};
  endfunction

endpackage

// File: rtl/clock_divider.sv
// Burst SCLK generator.
//   i_clk, i_rst_n : system clock, synchronous active-low reset
//   i_config       : {div[7:0], load}; load=1 while o_ready latches div
//   i_start_n      : low while o_ready starts an 8-period burst
//   o_clk          : generated clock, idles 0, low phase first
//   o_ready        : high when idle; low while configuring or bursting
// div must be even and >= 2; each phase lasts div/2 cycles.
module clock_divider (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [8:0] i_config,
  input  logic       i_start_n,
  output logic       o_clk,
  output logic       o_ready
);

  logic [7:0] div_r;
  logic [7:0] cnt;
  logic [4:0] edges;
  logic       running;

  // cnt steps down by 2 from div so a phase lasts div/2 cycles
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      div_r   <= 8'd2;
      cnt     <= '0;
      edges   <= '0;
      running <= 1'b0;
      o_clk   <= 1'b0;
      o_ready <= 1'b1;
    end else if (running) begin
      if (cnt == 8'd2) begin
        o_clk <= ~o_clk;
        cnt   <= div_r;
        edges <= edges - 5'd1;
        if (edges == 5'd1) begin
          running <= 1'b0;
          o_ready <= 1'b1;
        end
      end else begin
        cnt <= cnt - 8'd2;
      end
    end else if (o_ready && i_config[0]) begin
      div_r   <= i_config[8:1];
      o_ready <= 1'b0;
    end else if (o_ready && !i_start_n) begin
      running <= 1'b1;
      o_ready <= 1'b0;
      cnt     <= div_r;
      edges   <= 5'd16;
    end else begin
      o_ready <= 1'b1;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 byte master sequencing one clock_divider.
//   i_clk, i_rst_n          : system clock, synchronous active-low reset
//   i_div, i_div_load       : pending SCLK divisor update (any state)
//   i_tx_data/valid/last    : transmit byte request; last releases CS after it
//   o_tx_ready              : byte accepted when high with i_tx_valid
//   o_rx_data, o_rx_valid   : received byte, 1-cycle valid pulse
//   o_busy                  : high outside IDLE
//   o_sclk, o_mosi, i_miso, o_cs_n : SPI pins
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter logic [7:0] DEFAULT_DIV = 8'd4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_div,
  input  logic       i_div_load,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_busy,
  output logic       o_sclk,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic       o_cs_n
);

  state_t     state, state_nxt;
  cfg_t       cfg;
  logic       start_n;
  logic       div_clk;
  logic       div_ready;
  logic [7:0] pend_div;
  logic [7:0] div_act;
  logic [7:0] cnt;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic [2:0] bit_cnt;
  logic       dirty;
  logic       cfg_sent;
  logic       last_r;
  logic       sclk_q;
  logic       rise;
  logic       fall;
  logic       accept;
  logic       tx_ready;
  logic       cfg_done;

  clock_divider u_div (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_config (cfg),
    .i_start_n(start_n),
    .o_clk    (div_clk),
    .o_ready  (div_ready)
  );

  assign o_sclk     = div_clk;
  assign o_tx_ready = tx_ready;
  assign rise       = div_clk & ~sclk_q;
  assign fall       = ~div_clk & sclk_q;
  // A divisor load in the same cycle wins over the byte request.
  assign accept     = tx_ready & i_tx_valid & ~i_div_load;
  assign cfg_done   = (state == ST_CONFIG) && cfg_sent && div_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_CONFIG;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CONFIG: if (cfg_sent && div_ready) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (dirty)       state_nxt = ST_CONFIG;
        else if (accept) state_nxt = ST_SETUP;
      end
      ST_SETUP:  if (cnt == '0 && !div_ready) state_nxt = ST_RUN;
      ST_RUN:    if (div_ready) state_nxt = last_r ? ST_HOLD : ST_IDLE;
      ST_HOLD:   if (cnt == 8'd2) state_nxt = ST_IDLE;
      default:   state_nxt = ST_CONFIG;
    endcase
  end

  always_comb begin
    o_busy   = (state != ST_IDLE);
    tx_ready = (state == ST_IDLE) && !dirty;
    start_n  = !((state == ST_SETUP) && (cnt == '0));
    cfg      = '0;
    if (state == ST_CONFIG && !cfg_sent) begin
      cfg.div  = pend_div;
      cfg.load = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pend_div   <= DEFAULT_DIV;
      div_act    <= DEFAULT_DIV;
      dirty      <= 1'b1;
      cfg_sent   <= 1'b0;
      cnt        <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      bit_cnt    <= '0;
      last_r     <= 1'b0;
      sclk_q     <= 1'b0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_mosi     <= 1'b0;
      o_cs_n     <= 1'b1;
    end else begin
      sclk_q     <= div_clk;
      o_rx_valid <= 1'b0;

      if (i_div_load) pend_div <= sanitize_div(i_div);

      // A load landing mid-configuration keeps dirty set so the newer
      // divisor gets its own CONFIG pass.
      if (i_div_load)    dirty <= 1'b1;
      else if (cfg_done) dirty <= (pend_div != div_act);

      case (state)
        ST_CONFIG: begin
          if (!cfg_sent && div_ready) div_act <= pend_div;
          if (!div_ready)             cfg_sent <= 1'b1;
          if (cfg_done)               cfg_sent <= 1'b0;
        end
        ST_IDLE: begin
          if (accept) begin
            tx_sh   <= i_tx_data;
            last_r  <= i_tx_last;
            o_cs_n  <= 1'b0;
            o_mosi  <= i_tx_data[7];
            cnt     <= div_act;
            bit_cnt <= '0;
          end
        end
        ST_SETUP: begin
          if (cnt != '0) cnt <= cnt - 8'd2;
        end
        ST_RUN: begin
          if (rise) rx_sh <= {rx_sh[6:0], i_miso};
          // The eighth falling edge ends the burst; MOSI keeps bit 0.
          if (fall && bit_cnt != 3'd7) begin
            tx_sh   <= {tx_sh[6:0], 1'b0};
            o_mosi  <= tx_sh[6];
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (div_ready) begin
            o_rx_data  <= rx_sh;
            o_rx_valid <= 1'b1;
            cnt        <= div_act;
          end
        end
        ST_HOLD: begin
          if (cnt == 8'd2) o_cs_n <= 1'b1;
          else             cnt <= cnt - 8'd2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] div;
  logic       div_load;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  int passes = 0;
  int total  = 0;

  // monitor state
  int       cyc = 0;
  logic     prev_sclk = 1'b0;
  int       last_rise = 0;
  int       period = 0;
  int       rises = 0;
  logic [7:0] mosi_bits = '0;
  int       rxv_cnt = 0;
  int       cs_high_cnt = 0;

  int rb, rv, csb;

  assign miso = mosi;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.DEFAULT_DIV(8'd4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_div     (div),
    .i_div_load(div_load),
    .i_tx_data (tx_data),
    .i_tx_valid(tx_valid),
    .i_tx_last (tx_last),
    .o_tx_ready(tx_ready),
    .o_rx_data (rx_data),
    .o_rx_valid(rx_valid),
    .o_busy    (busy),
    .o_sclk    (sclk),
    .o_mosi    (mosi),
    .i_miso    (miso),
    .o_cs_n    (cs_n)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sclk && !prev_sclk) begin
      period    = cyc - last_rise;
      last_rise = cyc;
      rises     = rises + 1;
      mosi_bits = {mosi_bits[6:0], mosi};
    end
    prev_sclk = sclk;
    if (rx_valid) rxv_cnt = rxv_cnt + 1;
    if (cs_n) cs_high_cnt = cs_high_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_tx_ready(input string tag);
    int t = 0;
    while (!tx_ready && t < 500) begin
      tick();
      t++;
    end
    check(tag, tx_ready, 1'b1);
  endtask

  task automatic wait_rx(input string tag);
    int t = 0;
    while (!rx_valid && t < 3000) begin
      tick();
      t++;
    end
    check(tag, rx_valid, 1'b1);
  endtask

  task automatic send(input logic [7:0] d, input logic last, input string tag);
    wait_tx_ready(tag);
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] d);
    div      = d;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cs_n"},     cs_n,     1'b1);
    check({pfx, "_sclk"},     sclk,     1'b0);
    check({pfx, "_rx_valid"}, rx_valid, 1'b0);
    check({pfx, "_tx_ready"}, tx_ready, 1'b0);
    check({pfx, "_busy"},     busy,     1'b1);
    check({pfx, "_rx_data"},  rx_data,  8'h00);
    check({pfx, "_mosi"},     mosi,     1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    div      = '0;
    div_load = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;

    // reset and default configuration
    tick();
    check_reset_outputs("rst");
    tick(15);
    rst_n = 1'b1;
    wait_tx_ready("cfg_default_ready");
    check("cfg_default_busy", busy, 1'b0);

    // div=2, single byte with loopback
    load(8'd2);
    check("load_drops_ready", tx_ready, 1'b0);
    rb = rises;
    rv = rxv_cnt;
    send(8'hA5, 1'b1, "a5_ready");
    check("a5_cs_low", cs_n, 1'b0);
    wait_rx("a5_rx_timeout");
    check("a5_rx_data", rx_data, 8'hA5);
    check("a5_mosi_bits", mosi_bits, 8'hA5);
    check("a5_rises", rises - rb, 8);
    check("a5_period", period, 2);
    check("a5_cs_hold", cs_n, 1'b0);
    tick();
    check("a5_cs_release", cs_n, 1'b1);
    tick(4);
    check("a5_one_rx_valid", rxv_cnt - rv, 1);

    // div=4, back-to-back bytes under one CS
    load(8'd4);
    send(8'h3C, 1'b0, "b2b1_ready");
    wait_rx("b2b1_rx_timeout");
    check("b2b1_rx_data", rx_data, 8'h3C);
    check("b2b1_period", period, 4);
    csb = cs_high_cnt;
    send(8'hC3, 1'b1, "b2b2_ready");
    wait_rx("b2b2_rx_timeout");
    check("b2b2_rx_data", rx_data, 8'hC3);
    check("b2b_cs_continuous", cs_high_cnt - csb, 0);
    tick();
    check("b2b_hold1_cs", cs_n, 1'b0);
    tick();
    check("b2b_hold2_cs", cs_n, 1'b1);

    // divisor sanitising: 7 -> 6, 0 -> 2
    load(8'd7);
    send(8'h00, 1'b1, "d7_ready");
    wait_rx("d7_rx_timeout");
    check("d7_period", period, 6);
    check("d7_rx_data", rx_data, 8'h00);
    load(8'd0);
    send(8'h81, 1'b1, "d0_ready");
    wait_rx("d0_rx_timeout");
    check("d0_period", period, 2);
    check("d0_rx_data", rx_data, 8'h81);

    // divisor load during RUN applies to the following byte only
    tick(3);
    send(8'hFF, 1'b1, "midrun_ready");
    tick(6);
    check("midrun_busy", busy, 1'b1);
    load(8'd8);
    wait_rx("midrun_rx_timeout");
    check("midrun_old_period", period, 2);
    check("midrun_rx_data", rx_data, 8'hFF);
    send(8'h5A, 1'b1, "newrate_ready");
    wait_rx("newrate_rx_timeout");
    check("newrate_period", period, 8);
    check("newrate_rx_data", rx_data, 8'h5A);

    // reset in the middle of a byte
    tick(4);
    send(8'hC3, 1'b1, "rstmid_ready");
    tick(10);
    rst_n = 1'b0;
    rv = rxv_cnt;
    tick();
    check_reset_outputs("rstmid");
    tick(2);
    rst_n = 1'b1;
    wait_tx_ready("rstmid_recover");
    check("rstmid_no_rx_valid", rxv_cnt - rv, 0);
    send(8'h66, 1'b1, "rstmid_ready2");
    wait_rx("rstmid_rx_timeout");
    check("rstmid_default_period", period, 4);
    check("rstmid_rx_data", rx_data, 8'h66);

    tick(4);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
